// File: rtl/seq_det_param_moore.sv
// seq_det_param_moore: Moore detector for an arbitrary LEN-bit serial pattern.
// The state is the number of pattern bits matched so far, 0..LEN. A mismatch
// falls back KMP-style to the longest pattern prefix that is still a suffix of
// the bits received. The next-state table is built at elaboration time.
// Optional feature macro: SEQDET_MATCH_CNT_EN adds a saturating match counter.
// Without it, match_cnt is tied to 0 and cnt_clr is ignored.
module seq_det_param_moore #(
  parameter int             LEN     = 3,
  parameter logic [LEN-1:0] PATTERN = 3'b101,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             ovl,
  input  logic             cnt_clr,
  output logic             det,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int SW = $clog2(LEN + 1);
  localparam int TW = 2 * (LEN + 1) * SW;

  typedef logic [SW-1:0] state_t;

  localparam state_t MATCH = state_t'(LEN);

  // Entry (2*k + b) holds T(k, b): the length of the longest pattern prefix that
  // is a suffix of "first k pattern bits followed by b". The length is capped at
  // LEN, so row LEN gives the overlapping fallback after a full match.
  function automatic logic [TW-1:0] build_table();
    logic [TW-1:0]  t;
    logic [LEN-1:0] p;
    logic           s;
    logic           ok;
    logic           found;
    int             j;
    t = '0;
    for (int k = 0; k <= LEN; k++) begin
      for (int b = 0; b < 2; b++) begin
        found = 1'b0;
        for (int c = (k < LEN) ? k + 1 : LEN; c >= 1; c--) begin
          if (!found) begin
            ok = 1'b1;
            for (int i = 0; i < c; i++) begin
              j = k + 1 - c + i;
              if (j == k) begin
                s = (b != 0);
              end else begin
                p = PATTERN >> (LEN - 1 - j);
                s = p[0];
              end
              p = PATTERN >> (LEN - 1 - i);
              if (s != p[0]) ok = 1'b0;
            end
            if (ok) begin
              t     = t | (TW'(c) << ((2 * k + b) * SW));
              found = 1'b1;
            end
          end
        end
      end
    end
    return t;
  endfunction

  localparam logic [TW-1:0] NXT = build_table();

  state_t state;
  state_t row;
  state_t nxt;
  logic   legal;
  int     idx;

  // Next-state lookup; leaving a match without overlap restarts from row 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it
    // unassigned, which would otherwise infer a latch.
    row   = '0;
    legal = (state <= MATCH);
    if (legal && !(state == MATCH && !ovl)) row = state;
    idx = 2 * int'(row) + int'(in);
    nxt = NXT[idx * SW +: SW];
  end

  // State register and registered Moore flag; illegal encodings recover to 0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state <= '0;
      det   <= 1'b0;
    end else if (!legal) begin
      state <= '0;
      det   <= 1'b0;
    end else if (in_valid) begin
      state <= nxt;
      det   <= (nxt == MATCH);
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  // Saturating count of valid edges that land in the match state; clear wins.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      match_cnt <= '0;
    end else if (in_valid && legal && nxt == MATCH && match_cnt != '1) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_det_param_moore.sv
// tb_seq_det_param_moore: scoreboard bench for three detector configurations
// sharing one stimulus stream. The reference model keeps the recent bit history
// and declares a match when the last LEN bits equal the pattern. A non-overlapped
// completed match cuts the history, so its bits are not reused.
module tb_seq_det_param_moore;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in = 1'b0;
  logic       in_valid = 1'b0;
  logic       ovl = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       det0, det1, det2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  seq_det_param_moore u0 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .ovl(ovl),
    .det(det0), .match_cnt(cnt0), .cnt_clr(cnt_clr)
  );

  seq_det_param_moore #(.LEN(4), .PATTERN(4'b1101), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .ovl(ovl),
    .det(det1), .match_cnt(cnt1), .cnt_clr(cnt_clr)
  );

  seq_det_param_moore #(.LEN(3), .PATTERN(3'b111), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .ovl(ovl),
    .det(det2), .match_cnt(cnt2), .cnt_clr(cnt_clr)
  );

  typedef struct packed {
    logic [2:0]  det;
    logic [31:0] c0;
    logic [31:0] c1;
    logic [31:0] c2;
  } exp_t;

  exp_t sb[$];

  int          errors = 0;
  int          checks = 0;

  int          lens[3] = '{3, 4, 3};
  logic [31:0] pats[3] = '{32'b101, 32'b1101, 32'b111};
  int          cws[3]  = '{8, 8, 2};
  logic [31:0] hist[3];
  int          nbits[3];
  logic        mdet[3];
  int          mcnt[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one configuration across one clock edge.
  function automatic void model(input int i, input logic b, input logic v,
                                input logic o, input logic clr, input logic r);
    logic [31:0] mask;
    int          cmax;
    mask = (32'd1 << lens[i]) - 32'd1;
    cmax = (1 << cws[i]) - 1;
    if (r) begin
      hist[i]  = '0;
      nbits[i] = 0;
      mdet[i]  = 1'b0;
      mcnt[i]  = 0;
    end else begin
      if (v) begin
        if (mdet[i] && !o) nbits[i] = 0;
        hist[i]  = {hist[i][30:0], b};
        nbits[i] = nbits[i] + 1;
        mdet[i]  = (nbits[i] >= lens[i]) && ((hist[i] & mask) == pats[i]);
      end
      if (clr) mcnt[i] = 0;
      else if (v && mdet[i] && mcnt[i] < cmax) mcnt[i] = mcnt[i] + 1;
    end
  endfunction

  // Drive one cycle of inputs and push the expected post-edge outputs.
  task automatic step(input logic b, input logic v, input logic o,
                      input logic clr, input logic r);
    exp_t e;
    @(negedge clk);
    in = b; in_valid = v; ovl = o; cnt_clr = clr; rst = r;
    for (int i = 0; i < 3; i++) model(i, b, v, o, clr, r);
    e.det = {mdet[2], mdet[1], mdet[0]};
`ifdef SEQDET_MATCH_CNT_EN
    e.c0 = mcnt[0]; e.c1 = mcnt[1]; e.c2 = mcnt[2];
`else
    e.c0 = 0; e.c1 = 0; e.c2 = 0;
`endif
    sb.push_back(e);
  endtask

  task automatic send(input logic [15:0] bits, input int n, input logic o);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, o, 1'b0, 1'b0);
  endtask

  task automatic stall(input int n, input logic o);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, o, 1'b0, 1'b0);
  endtask

  // Monitor: compare every presented output against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("det_101",   {31'd0, det0}, {31'd0, e.det[0]});
      check("det_1101",  {31'd0, det1}, {31'd0, e.det[1]});
      check("det_111",   {31'd0, det2}, {31'd0, e.det[2]});
      check("cnt_101",   {24'd0, cnt0}, e.c0);
      check("cnt_1101",  {24'd0, cnt1}, e.c1);
      check("cnt_111w2", {30'd0, cnt2}, e.c2);
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      hist[i] = '0; nbits[i] = 0; mdet[i] = 1'b0; mcnt[i] = 0;
    end

    // Reset state, then the non-overlapping 10101 stream.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'b10101, 5, 1'b0);
    // Overlapping 10101: two matches.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'b10101, 5, 1'b1);
    // 11101 for the 1101 instance: fallback to state 2, match on bit 5.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'b11101, 5, 1'b0);
    // Stall mid-pattern, complete, then stall while matched.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'b10, 2, 1'b1);
    stall(3, 1'b1);
    send(16'b1, 1, 1'b1);
    stall(3, 1'b1);
    send(16'b01, 2, 1'b1);
    // Run of ones: continuous overlap matches, then saturation of the 2-bit count.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'b111111, 6, 1'b1);
    send(16'b11, 2, 1'b1);
    // Clear coinciding with a match edge.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send(16'b11, 2, 1'b1);
    // Reset mid-pattern discards progress; reset overrides valid and clear.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'b10, 2, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    send(16'b1, 1, 1'b0);
    send(16'b01, 2, 1'b0);

    // Randomised traffic biased towards ones so all patterns hit often.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 59) == 0);
    end

    @(posedge clk);
    #2;
    check("sb_drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_det_param_moore.md
Name: seq_det_param_moore

Overview:
- Parametrised Moore sequence detector: generalises the fixed 3-bit detectors to any LEN-bit pattern.
- Adds a runtime overlap/non-overlap mode, an input-valid qualifier and an optional saturating match counter.
- Sits on a 1-bit serial stream (one bit per valid cycle); asserts a registered-state match flag.

Parameters:
- LEN, 3, pattern length in bits; legal 1..32.
- PATTERN, 3'b101, LEN-bit pattern; PATTERN[LEN-1] is the first bit received.
- CNT_W, 8, width of match counter (counter feature only); legal 1..32.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in  input  1  serial data bit.
- in_valid  input  1  bit qualifier; state advances only when 1.
- ovl  input  1  mode: 1 = overlapping detection, 0 = non-overlapping.
- det  output  1  Moore match flag; 1 iff state == LEN.
- match_cnt  output  CNT_W  saturating match count (0 when feature disabled).
- cnt_clr  input  1  synchronous clear of match_cnt.

Behaviour:
- Reset: one clock with rst=1 forces state=0 (det=0) and match_cnt=0. rst overrides in_valid, ovl and cnt_clr. Reset mid-pattern discards partial progress.
- State: k = 0..LEN = number of pattern bits currently matched. Width is clog2(LEN+1). Unused encodings go to 0.
- Transition fn T(k,b), for k<LEN: length of the longest prefix of PATTERN that is a suffix of (first k pattern bits followed by b). This is KMP-style fallback, not a blind return to 0. T is computed at elaboration (function/generate); no runtime pattern load.
- From state LEN:
  - ovl=1: next = T(LEN,b), using the same suffix rule applied to the full pattern followed by b.
  - ovl=0: next = T(0,b); the completed match contributes no bits to the next one.
- ovl is sampled on the same edge as the bit and only matters when leaving state LEN.
- in_valid=0: state holds, det holds (a match stays visible), counter holds.
- det = (state == LEN), decoded purely from the state register, with no combinational path from in.
- Latency: the last pattern bit is sampled at edge N; det=1 from edge N until the next valid edge.
- LEN=1: state 1 is the match. Overlap and non-overlap behave identically.
- All-equal patterns (e.g. 111) in overlap mode stay in LEN while matching bits continue; det stays high and each valid bit is a new match.
- Counter (feature on):
  - Increments by 1 on every valid edge whose next state is LEN. This includes LEN->LEN in overlap mode.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 clears it to 0. If cnt_clr coincides with a match, clear wins and the result is 0.
  - The counter is independent of ovl changes.
- Default-case safety: any illegal state goes to 0 on the next edge, even with in_valid=0.

Optional Feature:
- Macro SEQDET_MATCH_CNT_EN.
- Defined: match_cnt counter implemented as above.
- Undefined: no counter flops; match_cnt tied to 0; cnt_clr ignored. Ports remain present so the instance is identical in both builds.

Test Plan:
- Defaults, ovl=0, in_valid=1, stream 1,0,1,0,1 -> det high only in the cycle after bit 3; match_cnt=1.
- Defaults, ovl=1, same stream 1,0,1,0,1 -> det high after bit 3 and after bit 5 (state 3->2->3); match_cnt=2.
- LEN=4, PATTERN=4'b1101, ovl=0, stream 1,1,1,0,1 -> fallback keeps state 2 after the third 1; det after bit 5; match_cnt=1.
- Defaults, ovl=1, stream 1,0, then in_valid=0 for 3 cycles, then 1 -> state holds at 2, det=0 while stalled; det=1 after the final bit. Repeat with a stall while det=1: det stays 1 and match_cnt is not incremented again.
- LEN=3, PATTERN=3'b111, ovl=1, six 1s -> det high after bits 3..6; match_cnt=4. With CNT_W=2 and 8 ones -> match_cnt saturates at 3. cnt_clr asserted on a match edge -> match_cnt=0.
- Assert rst after bits 1,0 of 101, then send 1 -> state goes to 1, no det. Build without SEQDET_MATCH_CNT_EN -> match_cnt constant 0 across all scenarios.
